// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with a per-entry
// busy scoreboard and a clear sequencer that zeroes every entry after reset
// or on request.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through forwarding of
// same-cycle writes to matching read ports).
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_req,
    output logic                           ready,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           alloc_en,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q;
    logic [ADDR_WIDTH-1:0]   clr_ptr_nxt;
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_nxt;
    logic                    ready_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_wa_c;
    logic [DATA_WIDTH-1:0]   mem_wd_c;
    logic                    wr_zero_c;
    logic                    alloc_zero_c;
    logic                    wr_ok_c;
    logic                    alloc_ok_c;

    // Qualify writes and allocs: only in IDLE, not with a clear, never to a hard-wired r0
    always_comb begin
        wr_zero_c    = (ZERO_REG != 0) && (waddr == '0);
        alloc_zero_c = (ZERO_REG != 0) && (alloc_addr == '0);
        wr_ok_c      = (state_q == ST_IDLE) && wen && !clear_req && !wr_zero_c;
        alloc_ok_c   = (state_q == ST_IDLE) && alloc_en && !clear_req && !alloc_zero_c;
    end

    // Next-state, sweep pointer, scoreboard update and memory write port selection
    always_comb begin
        state_nxt   = state_q;
        clr_ptr_nxt = clr_ptr_q;
        busy_nxt    = busy_q;
        mem_we_c    = 1'b0;
        mem_wa_c    = waddr;
        mem_wd_c    = wdata;
        ready_nxt   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_wa_c    = clr_ptr_q;
                mem_wd_c    = '0;
                clr_ptr_nxt = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_ptr_nxt = '0;
                    busy_nxt    = '0;
                end else begin
                    // Release first, then claim: a same-cycle alloc leaves the entry busy
                    if (wr_ok_c) begin
                        mem_we_c        = 1'b1;
                        busy_nxt[waddr] = 1'b0;
                    end
                    if (alloc_ok_c) begin
                        busy_nxt[alloc_addr] = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_ptr_nxt = '0;
                busy_nxt    = '0;
            end
        endcase

        ready_nxt = (state_nxt == ST_IDLE);
    end

    // Control state, sweep pointer, scoreboard and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            clr_ptr_q <= clr_ptr_nxt;
            busy_q    <= busy_nxt;
            ready     <= ready_nxt;
        end
    end

    // Storage array; contents are initialised by the sweep rather than by reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_wa_c] <= mem_wd_c;
        end
    end

    // Combinational read ports; forced to zero while sweeping and for a hard-wired r0
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            if ((state_q == ST_IDLE) &&
                !((ZERO_REG != 0) && (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                rbusy[i]                          = busy_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REG_FILE_BYPASS_EN
                // Forward an accepted same-cycle write straight to the reader
                if (wr_ok_c && (waddr == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
                    rbusy[i]                          = 1'b0;
                end
`endif
            end
        end
    end

endmodule
